// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
// A single full-subtractor cell is chained through a registered borrow under a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit;
  logic             br_next;
  logic             accept;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift = d_bit;
    end else begin : g_res_wn
      assign res_shift = {d_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  // New work is taken only between operations; start during RUN is ignored.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_shift;
          bout_d  = br_next;
        end
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      br_d   = bin;
      res_d  = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances checked every cycle
// against a timestamp-based arithmetic model, plus directed literal cases.
module tb_serial_subtractor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic int ref_diff(input int a, input int b, input int bin, input int w);
    int m;
    m = 1 << w;
    return ((a - b - bin) % m + m) % m;
  endfunction

  function automatic bit ref_bout(input int a, input int b, input int bin);
    return a < (b + bin);
  endfunction

  // Model: an accepted start at edge n yields done at edge n+W and busy on edges n..n+W-1.
  int         n8 = 0, end8 = 0;
  bit         act8 = 0;
  logic       m_busy8 = 0, m_done8 = 0, m_bout8 = 0, p_bout8 = 0;
  logic [7:0] m_diff8 = '0, p_diff8 = '0;

  int         n1 = 0, end1 = 0;
  bit         act1 = 0;
  logic       m_busy1 = 0, m_done1 = 0, m_bout1 = 0, p_bout1 = 0;
  logic [0:0] m_diff1 = '0, p_diff1 = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n8 = 0; act8 = 0; m_busy8 = 0; m_done8 = 0; m_diff8 = '0; m_bout8 = 0;
        n1 = 0; act1 = 0; m_busy1 = 0; m_done1 = 0; m_diff1 = '0; m_bout1 = 0;
      end else begin
        n8++;
        if (act8 && n8 == end8) begin m_diff8 = p_diff8; m_bout8 = p_bout8; end
        if (start8 && !m_busy8) begin
          act8 = 1; end8 = n8 + 8;
          p_diff8 = 8'(ref_diff(int'(a8), int'(b8), int'(bin8), 8));
          p_bout8 = ref_bout(int'(a8), int'(b8), int'(bin8));
        end
        m_busy8 = act8 && (n8 < end8);
        m_done8 = act8 && (n8 == end8);

        n1++;
        if (act1 && n1 == end1) begin m_diff1 = p_diff1; m_bout1 = p_bout1; end
        if (start1 && !m_busy1) begin
          act1 = 1; end1 = n1 + 1;
          p_diff1 = 1'(ref_diff(int'(a1), int'(b1), int'(bin1), 1));
          p_bout1 = ref_bout(int'(a1), int'(b1), int'(bin1));
        end
        m_busy1 = act1 && (n1 < end1);
        m_done1 = act1 && (n1 == end1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc busy8", busy8, m_busy8);
      chk("cyc done8", done8, m_done8);
      chk("cyc diff8", diff8, m_diff8);
      chk("cyc bout8", bout8, m_bout8);
      chk("cyc busy1", busy1, m_busy1);
      chk("cyc done1", done1, m_done1);
      chk("cyc diff1", diff1, m_diff1);
      chk("cyc bout1", bout1, m_bout1);
    end
  end

  // One WIDTH=8 operation from idle; poke pulses an ignored start mid-run.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bn,
                     input logic [7:0] ed, input logic eb, input bit poke, input string name);
    int first_done, ndone, nbusy;
    first_done = -1; ndone = 0; nbusy = 0;
    a8 = a; b8 = b; bin8 = bn; start8 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin
        ndone++;
        if (first_done < 0) first_done = k - 1;
      end
      start8 = 1'b0;
      if (poke && k == 3) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h00;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
    end
    $display("op8 %s: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d latency=%0d",
             name, a, b, bn, diff8, bout8, first_done);
    chk({name, " diff"}, diff8, ed);
    chk({name, " bout"}, bout8, eb);
    chk({name, " model diff"}, m_diff8, ed);
    chk({name, " latency"}, first_done, 8);
    chk({name, " done pulses"}, ndone, 1);
    chk({name, " busy cycles"}, nbusy, 8);
  endtask

  task automatic op1(input logic [2:0] i, input logic ed, input logic eb);
    int first_done, ndone;
    first_done = -1; ndone = 0;
    a1 = i[2]; b1 = i[1]; bin1 = i[0]; start1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        if (first_done < 0) first_done = k - 1;
      end
      start1 = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
    end
    $display("op1 a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d", i[2], i[1], i[0], diff1, bout1);
    chk("w1 diff", diff1, ed);
    chk("w1 bout", bout1, eb);
    chk("w1 latency", first_done, 1);
    chk("w1 done pulses", ndone, 1);
  endtask

  logic [7:0] tdiff = 8'b1001_0110;
  logic [7:0] tbout = 8'b1000_1110;
  logic [7:0] ha[3], hb[3], hd[3];
  logic       hbo[3];

  initial begin
    int idx, last_k, rdone;
    ha = '{8'h05, 8'h03, 8'h40};
    hb = '{8'h03, 8'h05, 8'h40};
    hd = '{8'h02, 8'hFE, 8'h00};
    hbo = '{1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset busy8", busy8, 0);
    chk("reset done8", done8, 0);
    chk("reset diff8", diff8, 0);
    chk("reset bout8", bout8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      op1(iv, tdiff[i], tbout[i]);
    end

    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, "5A-3C");
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "00-01");
    op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0, "80-7F-1");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "FF-FF-1");

    // Start held high across three back-to-back operations.
    idx = 0; last_k = 0;
    a8 = ha[0]; b8 = hb[0]; bin8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 60 && idx < 3; k++) begin
      @(negedge clk);
      chk("hold busy xor done", busy8 ^ done8, 1);
      if (done8) begin
        $display("hold op%0d: diff=%02h bout=%0d", idx, diff8, bout8);
        chk("hold diff", diff8, hd[idx]);
        chk("hold bout", bout8, hbo[idx]);
        if (idx > 0) chk("hold gap", k - last_k - 1, 8);
        last_k = k;
        idx++;
        if (idx < 3) begin a8 = ha[idx]; b8 = hb[idx]; end
        else start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    chk("hold completions", idx, 3);
    repeat (2) @(negedge clk);

    op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b1, "10-01 poke");

    // Asynchronous reset during cycle 4 of RUN.
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy8", busy8, 0);
    chk("abort done8", done8, 0);
    chk("abort diff8", diff8, 0);
    chk("abort bout8", bout8, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, "09-04 post-reset");

    // Random traffic on both instances; the per-cycle compare does the checking.
    rdone = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done8) rdone++;
      start8 = ($urandom_range(0, 3) == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
      start1 = ($urandom_range(0, 2) == 0);
      a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom_range(0, 1));
    end
    start8 = 1'b0; start1 = 1'b0;
    repeat (12) @(negedge clk);
    chk("random completions seen", (rdone > 20) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
